// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - state/result encodings and elaboration helpers for compare_seq
package compare_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Result as {big, equal, little}; consumers decode slt/sltu/branch conditions from these.
    localparam logic [2:0] RES_NONE   = 3'b000;
    localparam logic [2:0] RES_BIG    = 3'b100;
    localparam logic [2:0] RES_EQUAL  = 3'b010;
    localparam logic [2:0] RES_LITTLE = 3'b001;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/compare_slice.sv
// rtl/compare_slice.sv - combinational unsigned magnitude compare of one slice
module compare_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/compare_seq.sv
// rtl/compare_seq.sv - multi-cycle MSB-first magnitude comparator with early exit
module compare_seq
    import compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic             big,
    output logic             equal,
    output logic             little
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (clog2(NSLICE) > 1) ? clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
        $fatal(1, "compare_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op1, op2;
    logic [IDXW-1:0]  idx;
    logic [2:0]       res;
    logic [SLICE-1:0] slice1, slice2;
    logic             gt, lt, last;

    always_comb begin
        slice1 = op1[WIDTH-1 - int'(idx)*SLICE -: SLICE];
        slice2 = op2[WIDTH-1 - int'(idx)*SLICE -: SLICE];
    end

    assign last = (idx == LAST_IDX);

    compare_slice #(.SLICE(SLICE)) u_slice (
        .a  (slice1),
        .b  (slice2),
        .gt (gt),
        .lt (lt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (gt || lt || last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op1   <= '0;
            op2   <= '0;
            idx   <= '0;
            res   <= RES_NONE;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Flipping both sign bits maps two's-complement order onto unsigned order.
                        op1 <= data1 ^ (sgn ? MSB_MASK : '0);
                        op2 <= data2 ^ (sgn ? MSB_MASK : '0);
                        idx <= '0;
                        res <= RES_NONE;
                    end
                end
                S_RUN: begin
                    if (gt)        res <= RES_BIG;
                    else if (lt)   res <= RES_LITTLE;
                    else if (last) res <= RES_EQUAL;
                    else           idx <= idx + IDXW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign {big, equal, little} = res;

endmodule
